// File: rtl/mdu_pkg.sv
// Shared encodings for the sequential multiply/divide unit: opcodes, FSM states
// and opcode classification helpers.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MSUB  = 3'd5,
    OP_RSV6  = 3'd6,
    OP_RSV7  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } state_e;

  localparam int MUL_CNT_W = 2;

  function automatic logic is_div_op(op_e o);
    return (o == OP_DIV) || (o == OP_DIVU);
  endfunction

  // Reserved opcodes fall through to the unsigned multiply path.
  function automatic logic is_signed_mul(op_e o);
    return (o == OP_MULT) || (o == OP_MADD) || (o == OP_MSUB);
  endfunction

endpackage

// File: rtl/div_radix2.sv
// Radix-2 restoring divider on operand magnitudes. The first quotient bit is
// produced on the start edge, so all WIDTH bits are ready WIDTH-1 edges later.
module div_radix2 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clear,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             active_q, active_d;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] src_rem, src_quo, src_dvsr;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH:0]   shifted, diff;

  always_comb begin
    mag_a = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    mag_b = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

    src_rem  = start ? '0    : rem_q;
    src_quo  = start ? mag_a : quo_q;
    src_dvsr = start ? mag_b : dvsr_q;

    // Borrow out of the trial subtraction means "restore".
    shifted = {src_rem, src_quo[WIDTH-1]};
    diff    = shifted - {1'b0, src_dvsr};
    if (!diff[WIDTH]) begin
      step_rem = diff[WIDTH-1:0];
      step_quo = {src_quo[WIDTH-2:0], 1'b1};
    end else begin
      step_rem = shifted[WIDTH-1:0];
      step_quo = {src_quo[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (clear) begin
      active_d = 1'b0;
      cnt_d    = '0;
    end else if (en) begin
      if (start) begin
        rem_d    = step_rem;
        quo_d    = step_quo;
        dvsr_d   = mag_b;
        cnt_d    = CW'(WIDTH - 1);
        active_d = 1'b1;
      end else if (active_q && (cnt_q != '0)) begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q - CW'(1);
      end else if (active_q) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q    <= '0;
      quo_q    <= '0;
      dvsr_q   <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign done      = active_q && (cnt_q == '0);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/seq_mdu.sv
// Sequential multiply/divide unit with a hi/lo accumulator: pipelined multiply,
// MADD/MSUB, and restoring signed/unsigned divide.
//
// state   | meaning
// IDLE    | waiting for start
// MUL     | multiply pipeline draining
// DIV     | divider iterating, one quotient bit per cycle
// FIX     | sign correction / divide-by-zero substitution
// DONE    | result valid, done pulse, new start allowed
module seq_mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               clear,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result,
  output logic               busy,
  output logic               done
);

  localparam int DW = 2 * WIDTH;
  localparam logic [MUL_CNT_W-1:0] MUL_CNT_INIT =
    (MUL_LAT > 1) ? MUL_CNT_W'(MUL_LAT - 2) : '0;

  state_e                 state_q, state_d;
  logic [MUL_CNT_W-1:0]   mul_cnt_q, mul_cnt_d;
  op_e                    op_q, op_d;
  logic [WIDTH-1:0]       a_q, a_d;
  logic [WIDTH-1:0]       b_q, b_d;
  logic [DW-1:0]          result_q, result_d;
  logic [DW-1:0]          hilo_q, hilo_d;

  op_e                    op_in, mul_op;
  logic                   accept;
  logic                   div_start, div_done;
  logic [WIDTH-1:0]       div_quo, div_rem;
  logic [WIDTH-1:0]       quo_fix, rem_fix;
  logic                   div_sgn;
  logic [DW-1:0]          fix_res;
  logic [DW-1:0]          mul_in_prod, mul_prod, mul_res;

  assign op_in     = op_e'(op);
  assign accept    = start && en && !clear &&
                     ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign div_start = accept && is_div_op(op_in);

  // Extending to 2*WIDTH before multiplying keeps the product exact mod 2^DW.
  always_comb begin
    if (is_signed_mul(op_in))
      mul_in_prod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    else
      mul_in_prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  end

  generate
    if (MUL_LAT == 1) begin : g_mul_comb
      assign mul_prod = mul_in_prod;
    end else begin : g_mul_pipe
      logic [DW-1:0] pipe_q [MUL_LAT-1];
      logic [DW-1:0] pipe_d [MUL_LAT-1];

      always_comb begin
        for (int i = 0; i < MUL_LAT - 1; i++) pipe_d[i] = pipe_q[i];
        if (en) begin
          pipe_d[0] = accept ? mul_in_prod : pipe_q[0];
          for (int i = 1; i < MUL_LAT - 1; i++) pipe_d[i] = pipe_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < MUL_LAT - 1; i++) pipe_q[i] <= '0;
        end else begin
          for (int i = 0; i < MUL_LAT - 1; i++) pipe_q[i] <= pipe_d[i];
        end
      end

      assign mul_prod = pipe_q[MUL_LAT-2];
    end
  endgenerate

  // The final pipeline stage is the result register; accumulate there.
  assign mul_op = (MUL_LAT == 1) ? op_in : op_q;

  always_comb begin
    unique case (mul_op)
      OP_MADD: mul_res = hilo_q + mul_prod;
      OP_MSUB: mul_res = hilo_q - mul_prod;
      default: mul_res = mul_prod;
    endcase
  end

  div_radix2 #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .clear     (clear),
    .start     (div_start),
    .is_signed (op_in == OP_DIV),
    .dividend  (a),
    .divisor   (b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    div_sgn = (op_q == OP_DIV);
    quo_fix = (div_sgn && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -div_quo : div_quo;
    rem_fix = (div_sgn && a_q[WIDTH-1]) ? -div_rem : div_rem;
    if (b_q == '0) fix_res = {a_q, {WIDTH{1'b1}}};
    else           fix_res = {rem_fix, quo_fix};
  end

  always_comb begin
    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    hilo_d    = hilo_q;
    if (clear) begin
      state_d   = ST_IDLE;
      mul_cnt_d = '0;
    end else if (en) begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          state_d = ST_IDLE;
          if (accept) begin
            op_d = op_in;
            a_d  = a;
            b_d  = b;
            if (is_div_op(op_in)) begin
              state_d = ST_DIV;
            end else if (MUL_LAT == 1) begin
              state_d  = ST_DONE;
              result_d = mul_res;
              hilo_d   = mul_res;
            end else begin
              state_d   = ST_MUL;
              mul_cnt_d = MUL_CNT_INIT;
            end
          end
        end
        ST_MUL: begin
          if (mul_cnt_q == '0) begin
            state_d  = ST_DONE;
            result_d = mul_res;
            hilo_d   = mul_res;
          end else begin
            mul_cnt_d = mul_cnt_q - MUL_CNT_W'(1);
          end
        end
        ST_DIV: begin
          if (div_done) state_d = ST_FIX;
        end
        ST_FIX: begin
          state_d  = ST_DONE;
          result_d = fix_res;
          hilo_d   = fix_res;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      mul_cnt_q <= '0;
      op_q      <= OP_MULT;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      hilo_q    <= '0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      hilo_q    <= hilo_d;
    end
  end

  assign result = result_q;
  assign done   = (state_q == ST_DONE);
  assign busy   = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIX);

endmodule

// File: tb/tb_seq_mdu.sv
// Directed self-checking bench for seq_mdu at WIDTH=32, MUL_LAT=2.
module tb_seq_mdu;

  localparam int WIDTH   = 32;
  localparam int MUL_LAT = 2;

  logic              clk   = 1'b0;
  logic              rst   = 1'b1;
  logic              en    = 1'b1;
  logic              clear = 1'b0;
  logic              start = 1'b0;
  logic [2:0]        op    = 3'd0;
  logic [WIDTH-1:0]  a     = '0;
  logic [WIDTH-1:0]  b     = '0;
  logic [2*WIDTH-1:0] result;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  seq_mdu #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .clear  (clear),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Launch one operation and return the cycle (counted from the accept edge)
  // at which done is first seen, or -1 if it never comes.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output logic [63:0] res);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    res = '0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        res = result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #10;
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    // First start lands on the first edge after release; MADD also proves hilo reset to 0.
    @(negedge clk);
    rst = 1'b1; op = 3'd4; a = 32'd2; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_first_accept: busy got %b expected 1", busy); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL reset_madd_done: got %b expected 1", done); end
    checks++; if (result !== 64'd6) begin errors++; $display("FAIL reset_madd_hilo: got %h expected 6", result); end
  endtask

  task automatic test_mult();
    int lat;
    logic [63:0] res;
    run_op(3'd0, 32'hFFFF_FFFE, 32'd3, lat, res);
    checks++; if (lat !== 2) begin errors++; $display("FAIL mult_latency: got %0d expected 2", lat); end
    checks++; if (res !== 64'hFFFF_FFFF_FFFF_FFFA) begin errors++; $display("FAIL mult_signed: got %h expected ffffffff_fffffffa", res); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b expected 0", done); end
    checks++; if (result !== 64'hFFFF_FFFF_FFFF_FFFA) begin errors++; $display("FAIL result_hold: got %h expected ffffffff_fffffffa", result); end
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, lat, res);
    checks++; if (res !== 64'h0000_0002_FFFF_FFFA) begin errors++; $display("FAIL multu: got %h expected 2_fffffffa", res); end
  endtask

  task automatic test_div();
    vec_t v [6];
    int lat;
    logic [63:0] res;
    v[0] = '{op: 3'd2, a: 32'hFFFF_FFF9, b: 32'd2,          exp: 64'hFFFF_FFFF_FFFF_FFFD};
    v[1] = '{op: 3'd2, a: 32'h8000_0000, b: 32'hFFFF_FFFF, exp: 64'h0000_0000_8000_0000};
    v[2] = '{op: 3'd3, a: 32'd100,       b: 32'd7,          exp: 64'h0000_0002_0000_000E};
    v[3] = '{op: 3'd2, a: 32'd7,         b: 32'hFFFF_FFFE, exp: 64'h0000_0001_FFFF_FFFD};
    v[4] = '{op: 3'd3, a: 32'hFFFF_FFFF, b: 32'd16,         exp: 64'h0000_000F_0FFF_FFFF};
    v[5] = '{op: 3'd2, a: 32'hFFFF_FFF8, b: 32'hFFFF_FFFD, exp: 64'hFFFF_FFFE_0000_0002};
    for (int i = 0; i < 6; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, lat, res);
      checks++; if (lat !== 34) begin errors++; $display("FAIL div_latency[%0d]: got %0d expected 34", i, lat); end
      checks++; if (res !== v[i].exp) begin errors++; $display("FAIL div_result[%0d]: got %h expected %h", i, res, v[i].exp); end
    end
  endtask

  task automatic test_div_zero();
    int lat;
    logic [63:0] res;
    run_op(3'd3, 32'h1234_5678, 32'd0, lat, res);
    checks++; if (lat !== 34) begin errors++; $display("FAIL divu_zero_latency: got %0d expected 34", lat); end
    checks++; if (res !== 64'h1234_5678_FFFF_FFFF) begin errors++; $display("FAIL divu_zero: got %h expected 12345678_ffffffff", res); end
    run_op(3'd2, 32'hFFFF_FFF0, 32'd0, lat, res);
    checks++; if (res !== 64'hFFFF_FFF0_FFFF_FFFF) begin errors++; $display("FAIL div_zero_signed: got %h expected fffffff0_ffffffff", res); end
  endtask

  task automatic test_madd();
    int lat;
    logic [63:0] res;
    run_op(3'd0, 32'd5, 32'd6, lat, res);
    checks++; if (res !== 64'h1E) begin errors++; $display("FAIL madd_seed: got %h expected 1e", res); end
    run_op(3'd4, 32'd2, 32'd3, lat, res);
    checks++; if (lat !== 2) begin errors++; $display("FAIL madd_latency: got %0d expected 2", lat); end
    checks++; if (res !== 64'h24) begin errors++; $display("FAIL madd: got %h expected 24", res); end
    run_op(3'd5, 32'hFFFF_FFFF, 32'd1, lat, res);
    checks++; if (res !== 64'h25) begin errors++; $display("FAIL msub: got %h expected 25", res); end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [63:0] res;
    run_op(3'd1, 32'd7, 32'd9, lat, res);
    checks++; if (res !== 64'd63) begin errors++; $display("FAIL b2b_first: got %h expected 3f", res); end
    // Still in the DONE cycle: this start must be taken on the next edge.
    op = 3'd0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: busy got %b expected 1", busy); end
    lat = -1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (done) begin lat = n; break; end
    end
    checks++; if (lat !== 2) begin errors++; $display("FAIL b2b_latency: got %0d expected 2", lat); end
    checks++; if (result !== 64'd1) begin errors++; $display("FAIL b2b_result: got %h expected 1", result); end
    // A start while busy must not disturb the divide in flight.
    @(negedge clk);
    op = 3'd3; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n == 5) begin op = 3'd0; a = 32'd5; b = 32'd5; start = 1'b1; end
      if (n == 6) start = 1'b0;
      if (done) begin lat = n; break; end
    end
    start = 1'b0;
    checks++; if (lat !== 34) begin errors++; $display("FAIL busy_ignore_latency: got %0d expected 34", lat); end
    checks++; if (result !== 64'h0000_0002_0000_000E) begin errors++; $display("FAIL busy_ignore_result: got %h expected 2_0000000e", result); end
  endtask

  task automatic test_reserved_op();
    int lat;
    logic [63:0] res;
    run_op(3'd6, 32'hFFFF_FFFF, 32'd2, lat, res);
    checks++; if (lat !== 2) begin errors++; $display("FAIL rsv6_latency: got %0d expected 2", lat); end
    checks++; if (res !== 64'h0000_0001_FFFF_FFFE) begin errors++; $display("FAIL rsv6_result: got %h expected 1_fffffffe", res); end
    run_op(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res);
    checks++; if (res !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL rsv7_result: got %h expected fffffffe_00000001", res); end
  endtask

  task automatic test_freeze();
    int lat;
    @(negedge clk);
    op = 3'd3; a = 32'h1234_5678; b = 32'd16; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (n == 10) en = 1'b0;
      if (n == 15) en = 1'b1;
      if (done) begin lat = n; break; end
    end
    en = 1'b1;
    checks++; if (lat !== 39) begin errors++; $display("FAIL freeze_latency: got %0d expected 39", lat); end
    checks++; if (result !== 64'h0000_0008_0123_4567) begin errors++; $display("FAIL freeze_result: got %h expected 8_01234567", result); end
    en = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL freeze_done_hold: got %b expected 1", done); end
    en = 1'b1;
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL freeze_done_release: got %b expected 0", done); end
  endtask

  task automatic test_clear();
    logic [63:0] prev;
    logic seen;
    prev = result;
    @(negedge clk);
    op = 3'd3; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 10; n++) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_busy: got %b expected 0", busy); end
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL clear_no_done: activity got %b expected 0", seen); end
    checks++; if (result !== prev) begin errors++; $display("FAIL clear_result_kept: got %h expected %h", result, prev); end
  endtask

  task automatic test_rst_mid();
    int lat;
    logic [63:0] res;
    logic seen;
    @(negedge clk);
    op = 3'd2; a = 32'd77; b = 32'd5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 4; n++) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (result !== 64'h0) begin errors++; $display("FAIL rst_mid_result: got %h expected 0", result); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done: got %b expected 0", done); end
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_no_done: got %b expected 0", seen); end
    run_op(3'd1, 32'd3, 32'd5, lat, res);
    checks++; if (lat !== 2) begin errors++; $display("FAIL rst_mid_restart_latency: got %0d expected 2", lat); end
    checks++; if (res !== 64'd15) begin errors++; $display("FAIL rst_mid_restart_result: got %h expected f", res); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_madd();
    test_back_to_back();
    test_reserved_op();
    test_freeze();
    test_clear();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mdu.md
SEQ_MDU -- requirements
Module: seq_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand width (even, >= 8).
REQ-002 SHALL have parameter MUL_LAT, default 2, giving the multiply latency in cycles (1..4).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  pipeline enable; low freezes all internal state.
REQ-006 SHALL have port clear  input  1  synchronous abort of the in-flight operation.
REQ-007 SHALL have port start  input  1  request to begin an operation.
REQ-008 SHALL have port op  input  3  operation code: MULT, MULTU, DIV, DIVU, MADD, MSUB (mdu_pkg).
REQ-009 SHALL have port a  input  WIDTH  operand A (multiplicand or dividend).
REQ-010 SHALL have port b  input  WIDTH  operand B (multiplier or divisor).
REQ-011 SHALL have port result  output  2*WIDTH  {hi,lo}, held until the next completion.
REQ-012 SHALL have port busy  output  1  operation in flight.
REQ-013 SHALL have port done  output  1  one-cycle pulse; result is valid in that cycle.

Function
REQ-014 SHALL accept start only when busy=0, en=1 and clear=0; the acceptance edge is cycle 0, and operands and op are latched there.
REQ-015 SHALL ignore start while busy=1; the latched operands SHALL NOT change.
REQ-016 SHALL implement FSM states IDLE, MUL, DIV, FIX, DONE. Transitions: IDLE->MUL on accepted MULT/MULTU/MADD/MSUB; IDLE->DIV on accepted DIV/DIVU; MUL->DONE after MUL_LAT-1 cycles; DIV->FIX after WIDTH iterations; FIX->DONE; DONE->IDLE.
REQ-017 SHALL assert done exactly at cycle MUL_LAT for multiply-class ops and at cycle WIDTH+2 for divides, counting enabled cycles only.
REQ-018 SHALL, when en=0, hold state, counter, partial results and outputs; done SHALL stay asserted if frozen in DONE.
REQ-019 MULT SHALL produce the signed 2*WIDTH-bit product; MULTU SHALL produce the unsigned product.
REQ-020 MADD/MSUB SHALL compute the internal hilo register +/- the signed product, modulo 2^(2*WIDTH).
REQ-021 SHALL hold an internal hilo register, loaded with result on every done and used as the MADD/MSUB accumulator.
REQ-022 Divides SHALL use a radix-2 restoring algorithm on magnitudes, one quotient bit per cycle, with a sign fix in FIX.
REQ-023 Divide results: lo=quotient truncated toward zero; hi=remainder carrying the dividend's sign.
REQ-024 Signed overflow (min / -1): lo=min, hi=0.
REQ-025 Divide by zero: lo=all ones, hi=dividend, with the same latency as a normal divide.
REQ-026 clear SHALL return the FSM to IDLE at the next edge with no done pulse; result and hilo SHALL remain unchanged.
REQ-027 clear SHALL take priority over start and en in the same cycle.
REQ-028 busy SHALL be high in MUL, DIV and FIX, and low in IDLE and DONE; a new start MAY be accepted in the DONE cycle.

Reset
REQ-029 rst low SHALL asynchronously force: state IDLE, busy=0, done=0, result=0, hilo=0, counter=0.
REQ-030 Reset mid-operation SHALL discard the operation with no done pulse after release.
REQ-031 After rst deassertion, the first start SHALL be accepted on the first enabled edge.

Structure
REQ-032 mdu_pkg SHALL hold the op encodings (MULT=0, MULTU=1, DIV=2, DIVU=3, MADD=4, MSUB=5; others = no-op completing as MULTU) and the FSM state type.
REQ-033 The divider datapath (remainder, quotient, counter) SHALL be the single sub-module div_radix2, parameterised by WIDTH with start, en, clear and done ports.
REQ-034 The multiply datapath SHALL be a MUL_LAT-deep register pipeline inside seq_mdu.

Verification (WIDTH=32, MUL_LAT=2)
REQ-035 MULT a=0xFFFFFFFE, b=3 -> done at cycle 2, result=0xFFFFFFFF_FFFFFFFA.
REQ-036 DIV a=0xFFFFFFF9, b=2 -> done at cycle 34, lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 DIVU a=0x12345678, b=0 -> done at cycle 34, result=0x12345678_FFFFFFFF.
REQ-038 MULT 5*6 then MADD 2*3 -> result=0x24; then MSUB 0xFFFFFFFF*1 -> result=0x25.
REQ-039 DIVU started, en low for 5 cycles mid-operation -> done at cycle 39; a repeat with clear at cycle 10 -> busy=0 at cycle 11, no done, result unchanged.
REQ-040 rst asserted at cycle 5 of a DIV -> all outputs 0 immediately; no done after release; start on the next enabled edge is accepted.
